lcd_status_reader: RTL

// - Read side of the HD44780 LCD bus: runs an RS=0/RW=1 read cycle, samples busy flag (DB7) and address counter (DB6..0).
// - Optional poll-until-idle mode so the LCD command writer can wait on BF instead of fixed worst-case delays.
// - Sits beside the LCD writer; the top muxes LCD_RS/LCD_RW/LCD_EN and tri-states LCD_DATA while rd_owner=1.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_status_reader_if.sv | 30 +++
 rtl/lcd_phase_timer.sv | 37 +++
 rtl/lcd_status_reader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the HD44780 status-read path.
// The writer side reuses the same timing defaults and timer width.
package lcd_pkg;

    localparam int T_AS_DEF      = 3;
    localparam int T_EN_DEF      = 25;
    localparam int T_HOLD_DEF    = 2;
    localparam int T_GAP_DEF     = 20;
    localparam int MAX_POLLS_DEF = 2048;

    localparam int BF_BIT   = 7;
    localparam int ADDR_MSB = 6;

    localparam int TMR_W  = 8;
    localparam int POLL_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } rd_state_e;

endpackage

// File: rtl/lcd_status_reader_if.sv
// Request/result handshake plus the LCD control lines driven by the status reader.
// master = requesting side (writer or bench), slave = the reader itself.
interface lcd_status_reader_if;

    logic       rd_req;
    logic       rd_wait;
    logic [7:0] lcd_data_in;
    logic       rd_owner;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       rd_busy;
    logic       rd_done;
    logic       busy_flag;
    logic [6:0] addr_ctr;
    logic       rd_timeout;

    modport master (
        output rd_req, rd_wait, lcd_data_in,
        input  rd_owner, lcd_rs, lcd_rw, lcd_en, rd_busy, rd_done,
               busy_flag, addr_ctr, rd_timeout
    );

    modport slave (
        input  rd_req, rd_wait, lcd_data_in,
        output rd_owner, lcd_rs, lcd_rw, lcd_en, rd_busy, rd_done,
               busy_flag, addr_ctr, rd_timeout
    );

endinterface

// File: rtl/lcd_phase_timer.sv
// Phase down-counter: start_i reloads the count, expire_o is high while it reads 1.
// A phase of N cycles is therefore N cycles from the load edge to the advancing edge.
module lcd_phase_timer
    import lcd_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         start_i,
    input  logic [W-1:0] load_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = load_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 busy-flag/address read cycle with optional poll-until-idle mode.
// Only drives RS/RW/EN and ownership; the top-level mux owns the LCD_DATA tri-state.
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int T_AS      = T_AS_DEF,
    parameter int T_EN      = T_EN_DEF,
    parameter int T_HOLD    = T_HOLD_DEF,
    parameter int T_GAP     = T_GAP_DEF,
    parameter int MAX_POLLS = MAX_POLLS_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    lcd_status_reader_if.slave  bus
);

    // The poll counter must never wrap and every phase must fit the timer.
    generate
        if (MAX_POLLS < 1 || MAX_POLLS > 4095) begin : g_bad_polls
            $error("lcd_status_reader: MAX_POLLS must be in 1..4095");
        end
        if (T_AS < 1 || T_EN < 1 || T_HOLD < 1 || T_GAP < 1 ||
            T_AS > 255 || T_EN > 255 || T_HOLD > 255 || T_GAP > 255) begin : g_bad_timing
            $error("lcd_status_reader: phase lengths must be in 1..255");
        end
    endgenerate

    localparam logic [TMR_W-1:0]  L_AS     = TMR_W'(T_AS);
    localparam logic [TMR_W-1:0]  L_EN     = TMR_W'(T_EN);
    localparam logic [TMR_W-1:0]  L_HOLD   = TMR_W'(T_HOLD);
    localparam logic [TMR_W-1:0]  L_GAP    = TMR_W'(T_GAP);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

    rd_state_e          state_q, state_d;
    logic               tmr_start;
    logic [TMR_W-1:0]   tmr_load;
    logic               tmr_expire;
    logic               accept;
    logic               sample_en;
    logic               result_load;
    logic               timeout_set;

    logic               wait_q;
    logic [POLL_W-1:0]  poll_q;
    logic [7:0]         sample_q;
    logic               busy_flag_q;
    logic [ADDR_MSB:0]  addr_ctr_q;
    logic               rd_timeout_q;

    lcd_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (CLOCK_50),
        .srst     (reset),
        .start_i  (tmr_start),
        .load_i   (tmr_load),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        tmr_start   = 1'b0;
        tmr_load    = '0;
        accept      = 1'b0;
        sample_en   = 1'b0;
        result_load = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    accept    = 1'b1;
                    state_d   = ST_SETUP;
                    tmr_start = 1'b1;
                    tmr_load  = L_AS;
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    state_d   = ST_EN_HI;
                    tmr_start = 1'b1;
                    tmr_load  = L_EN;
                end
            end
            ST_EN_HI: begin
                if (tmr_expire) begin
                    sample_en = 1'b1;
                    state_d   = ST_HOLD;
                    tmr_start = 1'b1;
                    tmr_load  = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_expire) begin
                    if (!wait_q || !sample_q[BF_BIT]) begin
                        state_d     = ST_DONE;
                        result_load = 1'b1;
                    end else if (poll_q < POLL_MAX) begin
                        state_d   = ST_GAP;
                        tmr_start = 1'b1;
                        tmr_load  = L_GAP;
                    end else begin
                        state_d     = ST_DONE;
                        result_load = 1'b1;
                        timeout_set = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d   = ST_SETUP;
                    tmr_start = 1'b1;
                    tmr_load  = L_AS;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= 1'b0;
            poll_q       <= '0;
            sample_q     <= 8'h80;
            busy_flag_q  <= 1'b1;
            addr_ctr_q   <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wait_q       <= bus.rd_wait;
                poll_q       <= '0;
                rd_timeout_q <= 1'b0;
            end
            if (sample_en) begin
                sample_q <= bus.lcd_data_in;
                poll_q   <= poll_q + 1'b1;
            end
            // Results are published on entry to DONE so they are valid with rd_done.
            if (result_load) begin
                busy_flag_q  <= sample_q[BF_BIT];
                addr_ctr_q   <= sample_q[ADDR_MSB:0];
                rd_timeout_q <= timeout_set;
            end
        end
    end

    logic owner;
    assign owner = (state_q == ST_SETUP) || (state_q == ST_EN_HI) ||
                   (state_q == ST_HOLD)  || (state_q == ST_GAP);

    assign bus.rd_owner   = owner;
    assign bus.lcd_rs     = 1'b0;
    assign bus.lcd_rw     = owner;
    assign bus.lcd_en     = (state_q == ST_EN_HI);
    assign bus.rd_busy    = (state_q != ST_IDLE);
    assign bus.rd_done    = (state_q == ST_DONE);
    assign bus.busy_flag  = busy_flag_q;
    assign bus.addr_ctr   = addr_ctr_q;
    assign bus.rd_timeout = rd_timeout_q;

endmodule
